// File: rtl/ui_input_pkg.sv
// Shared constants for the KEY/SW memory-mapped input port: register
// addresses, control/status bit positions and the debounce length used in simulation.
package ui_input_pkg;

  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;

  localparam int SIM_DEBOUNCE_CYCLES = 4;

  function automatic logic [31:0] ctrlWord(input logic ready, input logic ovr);
    logic [31:0] word;
    word             = '0;
    word[CTRL_READY] = ready;
    word[CTRL_OVR]   = ovr;
    return word;
  endfunction

endpackage

// File: rtl/ui_input_if.sv
// Processor-side load/store port of the input front end.
interface ui_input_if #(
  parameter int DBITS = 32
);

  logic [DBITS-1:0] addr;
  logic             rdEn;
  logic             wrtEn;
  logic [DBITS-1:0] dataIn;
  logic [DBITS-1:0] dataOut;
  logic             hit;

  modport master (
    output addr, rdEn, wrtEn, dataIn,
    input  dataOut, hit
  );

  modport slave (
    input  addr, rdEn, wrtEn, dataIn,
    output dataOut, hit
  );

endinterface

// File: rtl/debounce_group.sv
// Two-flop synchronizer plus debounce counter for a vector of raw inputs.
// update pulses for the cycle whose edge loads newValue into the stable register.
module debounce_group #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawIn,
  output logic             update,
  output logic [WIDTH-1:0] newValue
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]    s1;
  logic [WIDTH-1:0]    s2;
  logic [WIDTH-1:0]    s2d;
  logic [WIDTH-1:0]    stable;
  logic [CNT_BITS-1:0] cnt;
  logic                settling;

  // Count only while the synchronized value is steady and differs from stable.
  assign settling = (s2 == s2d) && (s2 != stable);
  assign update   = settling && (cnt == CNT_LAST);
  assign newValue = s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      s2d    <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1  <= rawIn;
      s2  <= s1;
      s2d <= s2;
      if (!settling || update) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_BITS'(1);
      end
      if (update) begin
        stable <= s2;
      end
    end
  end

endmodule

// File: rtl/ui_input_port.sv
// Memory-mapped KEY/SW input port: debounced data registers with READY/OVR
// status, so software polls for change events instead of sampling raw pins.
module ui_input_port
  import ui_input_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int KEY_BITS        = 4,
  parameter int SW_BITS         = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] KEY,
  input  logic [SW_BITS-1:0]  SW,
  ui_input_if.slave           bus
);

  logic [KEY_BITS-1:0] keyPressed;
  logic                kUpdate;
  logic [KEY_BITS-1:0] kNew;
  logic                sUpdate;
  logic [SW_BITS-1:0]  sNew;

  logic [KEY_BITS-1:0] kData;
  logic [SW_BITS-1:0]  sData;
  logic                kReady;
  logic                kOvr;
  logic                sReady;
  logic                sOvr;

  logic selKData;
  logic selSData;
  logic selKCtrl;
  logic selSCtrl;
  logic kRead;
  logic sRead;
  logic kOvrClr;
  logic sOvrClr;

  // Buttons are active-low; invert up front so cleared sync flops mean "released".
  assign keyPressed = ~KEY;

  debounce_group #(
    .WIDTH          (KEY_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_BITS       (CNT_BITS)
  ) keyDebounce (
    .clk     (clk),
    .reset   (reset),
    .rawIn   (keyPressed),
    .update  (kUpdate),
    .newValue(kNew)
  );

  debounce_group #(
    .WIDTH          (SW_BITS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_BITS       (CNT_BITS)
  ) swDebounce (
    .clk     (clk),
    .reset   (reset),
    .rawIn   (SW),
    .update  (sUpdate),
    .newValue(sNew)
  );

  assign selKData = (bus.addr == DBITS'(ADDR_KDATA));
  assign selSData = (bus.addr == DBITS'(ADDR_SDATA));
  assign selKCtrl = (bus.addr == DBITS'(ADDR_KCTRL));
  assign selSCtrl = (bus.addr == DBITS'(ADDR_SCTRL));
  assign bus.hit  = selKData | selSData | selKCtrl | selSCtrl;

  assign kRead   = bus.rdEn && selKData;
  assign sRead   = bus.rdEn && selSData;
  assign kOvrClr = bus.wrtEn && selKCtrl && !bus.dataIn[CTRL_OVR];
  assign sOvrClr = bus.wrtEn && selSCtrl && !bus.dataIn[CTRL_OVR];

  // An update beats a same-cycle read (READY stays set) and an overrun beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kData  <= '0;
      sData  <= '0;
      kReady <= 1'b0;
      kOvr   <= 1'b0;
      sReady <= 1'b0;
      sOvr   <= 1'b0;
    end else begin
      if (kUpdate) begin
        kData <= kNew;
      end
      if (sUpdate) begin
        sData <= sNew;
      end
      kReady <= kUpdate | (kReady & ~kRead);
      sReady <= sUpdate | (sReady & ~sRead);
      kOvr   <= (kUpdate & kReady & ~kRead) | (kOvr & ~kOvrClr);
      sOvr   <= (sUpdate & sReady & ~sRead) | (sOvr & ~sOvrClr);
    end
  end

  always_comb begin
    bus.dataOut = '0;
    if (selKData) begin
      bus.dataOut = DBITS'(kData);
    end else if (selSData) begin
      bus.dataOut = DBITS'(sData);
    end else if (selKCtrl) begin
      bus.dataOut = DBITS'(ctrlWord(kReady, kOvr));
    end else if (selSCtrl) begin
      bus.dataOut = DBITS'(ctrlWord(sReady, sOvr));
    end
  end

endmodule

// File: tb/tb_ui_input_port.sv
// Self-checking bench for ui_input_port: directed scenarios plus random traffic,
// compared against a sample-history reference model of the debounce rules.
module tb_ui_input_port;
  import ui_input_pkg::*;

  localparam int D  = SIM_DEBOUNCE_CYCLES;
  localparam int HD = D + 2;
  localparam logic [31:0] ADDR_NONE = 32'hF000_0018;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [3:0] keyV;
  logic [9:0] swV;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] addrTable [0:4] = '{ADDR_KDATA, ADDR_SDATA, ADDR_KCTRL, ADDR_SCTRL, ADDR_NONE};

  ui_input_if #(.DBITS(32)) bus ();

  ui_input_port #(
    .DBITS          (32),
    .KEY_BITS       (4),
    .SW_BITS        (10),
    .DEBOUNCE_CYCLES(D),
    .CNT_BITS       (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .KEY  (KEY),
    .SW   (SW),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  // Reference model: hist[n] holds the pressed-domain input sampled n edges ago.
  // A group accepts a value once the D+1 samples taken 2..D+2 edges back agree
  // and differ from the current data; reset makes all pre-release samples zero.
  logic [3:0] kHist [0:HD-1];
  logic [9:0] sHist [0:HD-1];
  logic [3:0] mKData;
  logic [9:0] mSData;
  logic       mKReady, mKOvr, mSReady, mSOvr;
  logic       kSettle, sSettle, kUpd, sUpd, kRd, sRd, kClr, sClr;

  always_comb begin
    kSettle = 1'b1;
    sSettle = 1'b1;
    for (int i = 2; i < HD; i++) begin
      if (kHist[i] != kHist[1]) kSettle = 1'b0;
      if (sHist[i] != sHist[1]) sSettle = 1'b0;
    end
    kUpd = kSettle && (kHist[1] != mKData);
    sUpd = sSettle && (sHist[1] != mSData);
    kRd  = bus.rdEn && (bus.addr == ADDR_KDATA);
    sRd  = bus.rdEn && (bus.addr == ADDR_SDATA);
    kClr = bus.wrtEn && (bus.addr == ADDR_KCTRL) && !bus.dataIn[2];
    sClr = bus.wrtEn && (bus.addr == ADDR_SCTRL) && !bus.dataIn[2];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HD; i++) begin
        kHist[i] <= '0;
        sHist[i] <= '0;
      end
      mKData  <= '0;
      mSData  <= '0;
      mKReady <= 1'b0;
      mKOvr   <= 1'b0;
      mSReady <= 1'b0;
      mSOvr   <= 1'b0;
    end else begin
      kHist[0] <= ~KEY;
      sHist[0] <= SW;
      for (int i = 1; i < HD; i++) begin
        kHist[i] <= kHist[i-1];
        sHist[i] <= sHist[i-1];
      end
      if (kUpd) mKData <= kHist[1];
      if (sUpd) mSData <= sHist[1];
      mKReady <= kUpd ? 1'b1 : (kRd ? 1'b0 : mKReady);
      mSReady <= sUpd ? 1'b1 : (sRd ? 1'b0 : mSReady);
      mKOvr   <= (kUpd && mKReady && !kRd) ? 1'b1 : (kClr ? 1'b0 : mKOvr);
      mSOvr   <= (sUpd && mSReady && !sRd) ? 1'b1 : (sClr ? 1'b0 : mSOvr);
    end
  end

  function automatic logic [31:0] expRead(input logic [31:0] a);
    case (a)
      ADDR_KDATA: return {28'd0, mKData};
      ADDR_SDATA: return {22'd0, mSData};
      ADDR_KCTRL: return {29'd0, mKOvr, 1'b0, mKReady};
      ADDR_SCTRL: return {29'd0, mSOvr, 1'b0, mSReady};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] expHit(input logic [31:0] a);
    return {31'd0, (a == ADDR_KDATA) || (a == ADDR_SDATA) || (a == ADDR_KCTRL) || (a == ADDR_SCTRL)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One bus cycle: sweep every address against the model, then drive the
  // requested access and input pins, which stay put through the next edge.
  task automatic applyStimulus(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] din);
    @(negedge clk);
    bus.rdEn   = 1'b0;
    bus.wrtEn  = 1'b0;
    bus.dataIn = '0;
    for (int i = 0; i < 5; i++) begin
      bus.addr = addrTable[i];
      #1;
      checkOutput("sweep", bus.dataOut, expRead(addrTable[i]));
    end
    bus.addr   = a;
    bus.rdEn   = rd;
    bus.wrtEn  = wr;
    bus.dataIn = din;
    KEY        = keyV;
    SW         = swV;
    #1;
    checkOutput("access", bus.dataOut, expRead(a));
    checkOutput("hit", {31'd0, bus.hit}, expHit(a));
  endtask

  task automatic checkReg(input string tag, input logic [31:0] a, input logic [31:0] expected);
    applyStimulus(a, 1'b0, 1'b0, 32'd0);
    checkOutput(tag, bus.dataOut, expected);
  endtask

  // Called right after the cycle that presented a change: READY must stay low
  // through edge D+2 and rise exactly at edge D+3.
  task automatic waitUpdate(input string tag, input logic [31:0] ctrlA, input logic [31:0] dataA,
                            input logic [31:0] expData);
    for (int k = 1; k <= D + 2; k++) begin
      checkReg({tag, " early"}, ctrlA, 32'd0);
    end
    checkReg({tag, " ready"}, ctrlA, 32'd1);
    checkReg({tag, " data"}, dataA, expData);
  endtask

  initial begin
    KEY        = 4'hF;
    SW         = '0;
    keyV       = 4'hF;
    swV        = '0;
    bus.addr   = '0;
    bus.rdEn   = 1'b0;
    bus.wrtEn  = 1'b0;
    bus.dataIn = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    checkReg("reset kdata", ADDR_KDATA, 32'd0);
    checkReg("reset kctrl", ADDR_KCTRL, 32'd0);
    checkReg("reset sctrl", ADDR_SCTRL, 32'd0);
    checkReg("reset sdata", ADDR_SDATA, 32'd0);

    keyV = 4'hE;
    applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    waitUpdate("key press", ADDR_KCTRL, ADDR_KDATA, 32'h1);
    applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    checkOutput("kdata read value", bus.dataOut, 32'h1);
    checkReg("kctrl after read", ADDR_KCTRL, 32'd0);

    keyV = 4'hF;
    applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    waitUpdate("key release", ADDR_KCTRL, ADDR_KDATA, 32'h0);
    applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      keyV = ((i / 2) % 2 == 1) ? 4'hF : 4'hE;
      applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    end
    checkReg("bounce no update", ADDR_KCTRL, 32'd0);
    keyV = 4'hE;
    applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    waitUpdate("bounce settle", ADDR_KCTRL, ADDR_KDATA, 32'h1);

    swV = 10'h3FF;
    applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    waitUpdate("sw 3ff", ADDR_SCTRL, ADDR_SDATA, 32'h3FF);
    swV = 10'h155;
    repeat (D + 5) applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    checkReg("sw data 155", ADDR_SDATA, 32'h155);
    checkReg("sw overrun", ADDR_SCTRL, 32'h5);
    applyStimulus(ADDR_SCTRL, 1'b0, 1'b1, 32'h0);
    checkReg("sw ovr cleared", ADDR_SCTRL, 32'h1);
    applyStimulus(ADDR_SDATA, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkReg("sdata write ignored", ADDR_SDATA, 32'h155);

    applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    keyV = 4'hA;
    applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    for (int k = 1; k <= D + 1; k++) begin
      applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    end
    applyStimulus(ADDR_KDATA, 1'b1, 1'b0, 32'd0);
    checkOutput("simul read old data", bus.dataOut, 32'h1);
    checkReg("simul kctrl", ADDR_KCTRL, 32'h1);
    checkReg("simul kdata", ADDR_KDATA, 32'h5);

    keyV = 4'hC;
    applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    repeat (4) applyStimulus(ADDR_NONE, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    bus.rdEn  = 1'b0;
    bus.wrtEn = 1'b0;
    bus.addr  = ADDR_KDATA;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid reset kdata", bus.dataOut, 32'd0);
    bus.addr = ADDR_KCTRL;
    #1;
    checkOutput("mid reset kctrl", bus.dataOut, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitUpdate("post reset", ADDR_KCTRL, ADDR_KDATA, 32'h3);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) keyV = 4'($urandom);
      if ($urandom_range(0, 15) == 0) swV = 10'($urandom);
      applyStimulus(addrTable[$urandom_range(0, 4)], ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
